mm_responder: RTL

- Main-memory model that sits on the far side of the MSHR's memory interface.
- Accepts miss requests (mm_req address, mm_req_operation, mm_req_valid) and buffers them in an in-order pending queue.
- After a fixed access latency, returns data tagged with the originating operation ID on mm_ret_data, mm_ret_operation and mm_ret_valid.
- Used as the MSHR's memory peer in block- and cache-level benches, and as the memory stub in cache integration.

---
 rtl/mm_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mm_responder.sv
// Main-memory model: in-order pending queue, fixed access latency, data = addr*3+1.
// Define MM_RET_BACKPRESSURE_EN to add the mm_ret_ready handshake on the return path.
module mm_responder #(
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_OPS     = 32,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned LATENCY     = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [TAG_WIDTH+INDEX_WIDTH-1:0] mm_req,
  input  logic [$clog2(NUM_OPS)-1:0]       mm_req_operation,
  input  logic                             mm_req_valid,
  output logic                             mm_req_ready,
  output logic [DATA_WIDTH-1:0]            mm_ret_data,
  output logic [$clog2(NUM_OPS)-1:0]       mm_ret_operation,
  output logic                             mm_ret_valid,
  output logic [$clog2(QUEUE_DEPTH):0]     pending_count
`ifdef MM_RET_BACKPRESSURE_EN
  ,
  input  logic                             mm_ret_ready
`endif
);

  localparam int unsigned AddrW = TAG_WIDTH + INDEX_WIDTH;
  localparam int unsigned OpW   = $clog2(NUM_OPS);
  localparam int unsigned PtrW  = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned DownW = $clog2(LATENCY + 1);
  localparam logic [CntW-1:0]  FullCount = CntW'(QUEUE_DEPTH);
  localparam logic [DownW-1:0] DownInit  = DownW'(LATENCY - 1);

  logic [AddrW-1:0]       addr_q [QUEUE_DEPTH];
  logic [AddrW-1:0]       addr_d [QUEUE_DEPTH];
  logic [OpW-1:0]         op_q   [QUEUE_DEPTH];
  logic [OpW-1:0]         op_d   [QUEUE_DEPTH];
  logic [DownW-1:0]       down_q [QUEUE_DEPTH];
  logic [DownW-1:0]       down_d [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] vld_q, vld_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   ret_valid_q, ret_valid_d;
  logic [OpW-1:0]         ret_op_q, ret_op_d;
  logic [DATA_WIDTH-1:0]  ret_data_q, ret_data_d;

  logic                   accept, pop, slot_free, dec;
  logic [DATA_WIDTH-1:0]  head_addr, head_data;

  assign mm_req_ready = ~rst & (count_q < FullCount);
  assign accept       = mm_req_valid & mm_req_ready;

`ifdef MM_RET_BACKPRESSURE_EN
  assign slot_free = ~ret_valid_q | mm_ret_ready;
  // The output slot is still counted as pending until the beat is taken.
  assign dec       = ret_valid_q & mm_ret_ready;
`else
  assign slot_free = 1'b1;
  assign dec       = pop;
`endif

  assign pop       = vld_q[rd_ptr_q] & (down_q[rd_ptr_q] == '0) & slot_free;
  assign head_addr = DATA_WIDTH'(addr_q[rd_ptr_q]);
  assign head_data = head_addr + (head_addr << 1) + DATA_WIDTH'(1);

  always_comb begin
    addr_d      = addr_q;
    op_d        = op_q;
    down_d      = down_q;
    vld_d       = vld_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ret_valid_d = ret_valid_q;
    ret_op_d    = ret_op_q;
    ret_data_d  = ret_data_q;

    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (vld_q[i] && down_q[i] != '0) down_d[i] = down_q[i] - DownW'(1);
    end

    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PtrW'(1);
      ret_valid_d     = 1'b1;
      ret_op_d        = op_q[rd_ptr_q];
      ret_data_d      = head_data;
    end else if (ret_valid_q && slot_free) begin
      ret_valid_d = 1'b0;
    end

    // A non-full count means the queue itself has room, so wr_ptr never hits the popped slot.
    if (accept) begin
      vld_d[wr_ptr_q]  = 1'b1;
      addr_d[wr_ptr_q] = mm_req;
      op_d[wr_ptr_q]   = mm_req_operation;
      down_d[wr_ptr_q] = DownInit;
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end

    unique case ({accept, dec})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ret_valid_q <= 1'b0;
      ret_op_q    <= '0;
      ret_data_q  <= '0;
    end else begin
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ret_valid_q <= ret_valid_d;
      ret_op_q    <= ret_op_d;
      ret_data_q  <= ret_data_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      down_q      <= down_d;
    end
  end

  assign mm_ret_valid     = ret_valid_q;
  assign mm_ret_operation = ret_op_q;
  assign mm_ret_data      = ret_data_q;
  assign pending_count    = count_q;

endmodule
